spi_peripheral: RTL and testbench

//  Target-side end of the CPU SPI link. Shifts a W_Data-bit word in from the controller on

---
 rtl/spi_peripheral.sv | 132 +++++++++++++
 tb/tb_spi_peripheral.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI target endpoint: shifts a W_Data-bit word in on MOSI_in while shifting a
// buffered reply out on MISO_out, MSB first, one bit per clk (clk is the SPI clock).
// A one-word reply buffer decouples the CPU-side load strobe from frame timing.
//
// state  | meaning
// IDLE   | no frame in progress; MISO_out pre-drives the buffered reply MSB
// SHIFT  | frame in progress; counter indexes the next receive bit
module spi_peripheral #(
  parameter int W_Data    = 32,
  parameter int W_Counter = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              MOSI_in,
  output logic              MISO_out,
  input  logic [W_Data-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [W_Data-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_error
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam logic [W_Counter-1:0] CNT_TOP   = W_Counter'(W_Data - 1);
  localparam logic [W_Counter-1:0] CNT_START = W_Counter'(W_Data - 2);

  logic                 state;
  logic [W_Counter-1:0] counter;
  // Bit 0 is never stored: it is taken straight from MOSI_in on the last edge.
  logic [W_Data-1:1]    rx_shift;
  // Holds the reply bits still to be presented; MSB is the next one out.
  logic [W_Data-2:0]    tx_shift;
  logic [W_Data-1:0]    buffer;
  logic                 buf_full;

  logic [W_Data-1:0]    buf_nxt;
  logic                 full_nxt;
  logic                 frame_start;
  logic                 predrive;

  assign tx_ready    = ~buf_full;
  assign frame_start = (state == ST_IDLE) && !cs_n;

  // Next reply-buffer contents: a load into an empty buffer wins over the
  // frame-start consume, which can only happen when the buffer is full anyway.
  always_comb begin
    buf_nxt  = buffer;
    full_nxt = buf_full;
    if (tx_load && !buf_full) begin
      buf_nxt  = tx_data;
      full_nxt = 1'b1;
    end else if (frame_start) begin
      buf_nxt  = '0;
      full_nxt = 1'b0;
    end
  end

  // MSB the controller should see before the next frame-start edge; uses the
  // next buffer value so a load is visible on MISO one cycle after it lands.
  assign predrive = full_nxt & buf_nxt[W_Data-1];

  // Frame sequencing, shift registers, reply buffer and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      counter     <= CNT_TOP;
      rx_shift    <= '0;
      tx_shift    <= '0;
      buffer      <= '0;
      buf_full    <= 1'b0;
      MISO_out    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
      buffer      <= buf_nxt;
      buf_full    <= full_nxt;
      case (state)
        ST_IDLE: begin
          if (!cs_n) begin
            state    <= ST_SHIFT;
            counter  <= CNT_START;
            rx_shift <= {MOSI_in, {(W_Data-2){1'b0}}};
            if (buf_full) begin
              tx_shift <= {buffer[W_Data-3:0], 1'b0};
              MISO_out <= buffer[W_Data-2];
            end else begin
              tx_shift    <= '0;
              MISO_out    <= 1'b0;
              tx_underrun <= 1'b1;
            end
          end else begin
            MISO_out <= predrive;
          end
        end
        ST_SHIFT: begin
          if (cs_n) begin
            state       <= ST_IDLE;
            counter     <= CNT_TOP;
            frame_error <= 1'b1;
            MISO_out    <= predrive;
          end else if (counter == '0) begin
            rx_data  <= {rx_shift, MOSI_in};
            rx_valid <= 1'b1;
            counter  <= CNT_TOP;
            state    <= ST_IDLE;
            MISO_out <= predrive;
          end else begin
            rx_shift[counter] <= MOSI_in;
            counter           <= counter - 1'b1;
            MISO_out          <= tx_shift[W_Data-2];
            tx_shift          <= {tx_shift[W_Data-3:0], 1'b0};
          end
        end
        default: begin
          state   <= ST_IDLE;
          counter <= CNT_TOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: expected receive words and MISO bits are
// queued as stimulus is driven and compared when the DUT produces them.
module tb_spi_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        MOSI_in;
  logic        MISO_out;
  logic [31:0] tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        tx_underrun;
  logic        frame_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int last_gap = 0;
  int n_rx = 0;
  int n_under = 0;
  int n_ferr = 0;
  int base_rx, base_under, base_ferr;
  logic rdy_after_start;

  logic [31:0] rx_q[$];
  logic        miso_q[$];

  spi_peripheral #(.W_Data(32), .W_Counter(5)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .MOSI_in(MOSI_in), .MISO_out(MISO_out),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, scoreboard any DUT output.
  task automatic tick();
    logic [31:0] e;
    logic        b;
    @(negedge clk);
    cyc++;
    if (rx_valid === 1'b1) begin
      last_gap    = cyc - last_rx_cyc;
      last_rx_cyc = cyc;
      n_rx++;
      if (rx_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
      else begin
        e = rx_q.pop_front();
        chk("rx_data", rx_data, e);
      end
    end
    if (tx_underrun === 1'b1) n_under++;
    if (frame_error === 1'b1) n_ferr++;
    if (miso_q.size() > 0) begin
      b = miso_q.pop_front();
      chk("miso_bit", {31'd0, MISO_out}, {31'd0, b});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      cs_n    = 1'b1;
      tx_load = 1'b0;
    end
  endtask

  task automatic load(input logic [31:0] d);
    tick();
    tx_data = d;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  // Drive nbits of a frame with cs_n low; optionally strobe tx_load at bit reload_at.
  task automatic frame(input logic [31:0] mosi, input logic [31:0] exp_miso, input int nbits,
                       input bit push_rx, input int reload_at, input logic [31:0] reload);
    for (int i = 0; i < nbits; i++) miso_q.push_back(exp_miso[31-i]);
    if (push_rx) rx_q.push_back(mosi);
    for (int i = 0; i < nbits; i++) begin
      tick();
      if (i == 1) rdy_after_start = tx_ready;
      cs_n    = 1'b0;
      MOSI_in = mosi[31-i];
      tx_load = 1'b0;
      if (i == reload_at) begin
        tx_data = reload;
        tx_load = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; MOSI_in = 1'b0; tx_data = '0; tx_load = 1'b0;
    @(negedge clk);
    chk("rst_miso", {31'd0, MISO_out}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_flags", {29'd0, rx_valid, tx_underrun, frame_error}, 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: loaded reply, normal frame
    load(32'hA5A5_0F0F);
    chk("t1_tx_ready_loaded", {31'd0, tx_ready}, 32'd0);
    base_rx = n_rx; base_under = n_under; base_ferr = n_ferr;
    frame(32'h1234_5678, 32'hA5A5_0F0F, 32, 1'b1, -1, '0);
    chk("t1_tx_ready_after_start", {31'd0, rdy_after_start}, 32'd1);
    idle(2);
    chk("t1_rx_count", n_rx - base_rx, 32'd1);
    chk("t1_no_underrun", n_under - base_under, 32'd0);
    chk("t1_no_ferr", n_ferr - base_ferr, 32'd0);

    // 2: empty buffer -> underrun, zeros sent
    base_under = n_under;
    frame(32'hFFFF_FFFF, 32'h0000_0000, 32, 1'b1, -1, '0);
    idle(2);
    chk("t2_underrun", n_under - base_under, 32'd1);
    chk("t2_rx_data_held", rx_data, 32'hFFFF_FFFF);

    // 3: abort after 12 bits, then a clean frame
    base_rx = n_rx; base_ferr = n_ferr;
    frame(32'hABCD_EF01, 32'h0000_0000, 12, 1'b0, -1, '0);
    idle(3);
    chk("t3_frame_error", n_ferr - base_ferr, 32'd1);
    chk("t3_no_rx_valid", n_rx - base_rx, 32'd0);
    chk("t3_rx_data_kept", rx_data, 32'hFFFF_FFFF);
    frame(32'hDEAD_BEEF, 32'h0000_0000, 32, 1'b1, -1, '0);
    idle(2);
    chk("t3_rx_after_abort", rx_data, 32'hDEAD_BEEF);

    // 4: back-to-back frames with reload during the first
    base_rx = n_rx; base_under = n_under;
    load(32'h1111_1111);
    frame(32'h0F1E_2D3C, 32'h1111_1111, 32, 1'b1, 2, 32'h2222_2222);
    frame(32'h4B5A_6978, 32'h2222_2222, 32, 1'b1, -1, '0);
    idle(2);
    chk("t4_rx_count", n_rx - base_rx, 32'd2);
    chk("t4_rx_gap", last_gap, 32'd32);
    chk("t4_no_underrun", n_under - base_under, 32'd0);

    // 5: load while full ignored; load on frame-start edge serves the next frame
    load(32'h0000_0001);
    load(32'hFFFF_FFFF);
    frame(32'h5555_AAAA, 32'h0000_0001, 32, 1'b1, -1, '0);
    idle(2);
    base_under = n_under;
    frame(32'h0000_0000, 32'h0000_0000, 32, 1'b1, 0, 32'hC3C3_3C3C);
    idle(2);
    chk("t5_start_load_underrun", n_under - base_under, 32'd1);
    chk("t5_tx_ready_pending", {31'd0, tx_ready}, 32'd0);
    frame(32'h7777_8888, 32'hC3C3_3C3C, 32, 1'b1, -1, '0);
    idle(2);

    // 6: reset mid-frame
    base_rx = n_rx; base_under = n_under; base_ferr = n_ferr;
    load(32'hF0F0_F0F0);
    frame(32'h9999_9999, 32'hF0F0_F0F0, 10, 1'b0, -1, '0);
    tick();
    rst  = 1'b1;
    cs_n = 1'b1;
    #1;
    chk("t6_rst_miso", {31'd0, MISO_out}, 32'd0);
    chk("t6_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("t6_rst_rx_data", rx_data, 32'd0);
    chk("t6_rst_flags", {29'd0, rx_valid, tx_underrun, frame_error}, 32'd0);
    tick();
    rst = 1'b0;
    idle(2);
    chk("t6_no_flags", (n_ferr - base_ferr) + (n_rx - base_rx) + (n_under - base_under), 32'd0);
    frame(32'h3141_5926, 32'h0000_0000, 32, 1'b1, -1, '0);
    idle(2);
    chk("t6_rx_after_reset", rx_data, 32'h3141_5926);

    chk("rx_missing", rx_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
